mouse_init_ctrl: RTL and testbench

MOUSE_INIT_CTRL -- requirements
Module: mouse_init_ctrl

---
 rtl/mouse_init_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_mouse_init_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_init_ctrl.sv
// rtl/mouse_init_ctrl.sv - PS/2 mouse initialisation sequencer with stream pass-through
//
// Sends the reset command (0xFF) and waits for ack, BAT result and device ID.
// It then enables data reporting (0xF4) and forwards every received byte to the
// packet decoder. A wrong byte or a silent wait restarts the sequence, up to
// MAX_RETRY times. A resend request (0xFE) repeats only the last command.
//
// Build option:
//   MOUSE_INIT_SAMPLE_RATE_EN  when defined, the sequence also sets the sample
//                              rate (0xF3, 0x64) between the ID and enable steps.
//
// Parameters:
//   TIMEOUT_CYCLES  response timeout per wait state, in clk cycles
//   MAX_RETRY       full restarts allowed before entering ERROR
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   start       one-cycle pulse; starts init from IDLE, ERROR or STREAM
//   tx_busy     byte transmitter busy
//   tx_start    one-cycle request to transmit tx_data
//   tx_data     command byte, held until the next send state
//   rx_ready    one-cycle strobe, rx_data valid
//   rx_data     received byte
//   mouseReady  stream byte strobe, one cycle after rx_ready in STREAM
//   mouseData   stream byte
//   mouseState  current state code
//   init_done   high in STREAM
//   init_error  high in ERROR

module mouse_init_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       mouseReady,
  output logic [7:0] mouseData,
  output logic [3:0] mouseState,
  output logic       init_done,
  output logic       init_error
);

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_SEND_RST     = 4'd1;
  localparam logic [3:0] S_WAIT_ACK_RST = 4'd2;
  localparam logic [3:0] S_WAIT_BAT     = 4'd3;
  localparam logic [3:0] S_WAIT_ID      = 4'd4;
  localparam logic [3:0] S_SEND_EN      = 4'd5;
  localparam logic [3:0] S_WAIT_ACK_EN  = 4'd6;
  localparam logic [3:0] S_STREAM       = 4'd7;
  localparam logic [3:0] S_ERROR        = 4'd8;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
  localparam logic [3:0] S_SEND_SR      = 4'd9;
  localparam logic [3:0] S_WAIT_ACK_SR  = 4'd10;
  localparam logic [3:0] S_SEND_RATE    = 4'd11;
  localparam logic [3:0] S_WAIT_ACK_RATE = 4'd12;
`endif

  localparam logic [7:0] B_ACK    = 8'hFA;
  localparam logic [7:0] B_BAT_OK = 8'hAA;
  localparam logic [7:0] B_ID     = 8'h00;
  localparam logic [7:0] B_RESEND = 8'hFE;

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  logic [3:0]    state;
  logic [3:0]    state_next;
  logic [RW-1:0] retry_cnt;
  logic [RW-1:0] retry_next;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    tx_data_q;
  logic          mouse_ready_q;
  logic [7:0]    mouse_data_q;

  // Decode of the current wait state: the byte it expects, where that byte
  // leads, and which send state a resend request returns to.
  logic          is_wait;
  logic [7:0]    expect_byte;
  logic [3:0]    ok_target;
  logic [3:0]    resend_target;
  logic [3:0]    fail_target;
  logic          fail;

  function automatic logic is_send_state(input logic [3:0] s);
    logic r;
    r = 1'b0;
    case (s)
      S_SEND_RST, S_SEND_EN: r = 1'b1;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
      S_SEND_SR, S_SEND_RATE: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] cmd_for(input logic [3:0] s);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      S_SEND_RST:  b = 8'hFF;
      S_SEND_EN:   b = 8'hF4;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
      S_SEND_SR:   b = 8'hF3;
      S_SEND_RATE: b = 8'h64;
`endif
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    state_next    = state;
    retry_next    = retry_cnt;
    is_wait       = 1'b0;
    expect_byte   = B_ACK;
    ok_target     = state;
    resend_target = S_SEND_RST;
    fail_target   = S_SEND_RST;
    fail          = 1'b0;

    case (state)
      S_IDLE, S_ERROR, S_STREAM: begin
        if (start) begin
          state_next = S_SEND_RST;
          retry_next = '0;
        end
      end
      S_SEND_RST: if (!tx_busy) state_next = S_WAIT_ACK_RST;
      S_SEND_EN:  if (!tx_busy) state_next = S_WAIT_ACK_EN;
      S_WAIT_ACK_RST: begin
        is_wait     = 1'b1;
        expect_byte = B_ACK;
        ok_target   = S_WAIT_BAT;
      end
      S_WAIT_BAT: begin
        is_wait     = 1'b1;
        expect_byte = B_BAT_OK;
        ok_target   = S_WAIT_ID;
      end
      S_WAIT_ID: begin
        is_wait     = 1'b1;
        expect_byte = B_ID;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
        ok_target   = S_SEND_SR;
`else
        ok_target   = S_SEND_EN;
`endif
      end
      S_WAIT_ACK_EN: begin
        is_wait       = 1'b1;
        expect_byte   = B_ACK;
        ok_target     = S_STREAM;
        resend_target = S_SEND_EN;
      end
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
      S_SEND_SR:   if (!tx_busy) state_next = S_WAIT_ACK_SR;
      S_SEND_RATE: if (!tx_busy) state_next = S_WAIT_ACK_RATE;
      S_WAIT_ACK_SR: begin
        is_wait       = 1'b1;
        expect_byte   = B_ACK;
        ok_target     = S_SEND_RATE;
        resend_target = S_SEND_SR;
      end
      S_WAIT_ACK_RATE: begin
        is_wait       = 1'b1;
        expect_byte   = B_ACK;
        ok_target     = S_SEND_EN;
        resend_target = S_SEND_RATE;
      end
`endif
      default: state_next = S_IDLE;
    endcase

    // A received byte takes priority over a timeout expiring the same cycle.
    if (is_wait) begin
      if (rx_ready) begin
        if (rx_data == expect_byte) begin
          state_next = ok_target;
        end else begin
          fail = 1'b1;
          if (rx_data == B_RESEND) fail_target = resend_target;
        end
      end else if (tmo_cnt == TMO_LIMIT) begin
        fail = 1'b1;
      end

      if (fail) begin
        if (retry_cnt < RETRY_LIMIT) begin
          retry_next = retry_cnt + RW'(1);
          state_next = fail_target;
        end else begin
          state_next = S_ERROR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      retry_cnt     <= '0;
      tmo_cnt       <= '0;
      tx_data_q     <= 8'h00;
      mouse_ready_q <= 1'b0;
      mouse_data_q  <= 8'h00;
    end else begin
      state     <= state_next;
      retry_cnt <= retry_next;

      // Counts cycles spent in the current wait state; restarts on any
      // state change and parks at the limit instead of wrapping.
      if (!is_wait || (state_next != state)) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LIMIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      // The command byte is latched on the way into a send state so it is
      // already valid when tx_start fires and stays put through the wait.
      if (is_send_state(state_next)) begin
        tx_data_q <= cmd_for(state_next);
      end

      // A start in STREAM leaves the state, so the strobe is dropped.
      if ((state == S_STREAM) && !start) begin
        mouse_ready_q <= rx_ready;
        if (rx_ready) mouse_data_q <= rx_data;
      end else begin
        mouse_ready_q <= 1'b0;
      end
    end
  end

  assign tx_start   = is_send_state(state) && !tx_busy;
  assign tx_data    = tx_data_q;
  assign mouseReady = mouse_ready_q;
  assign mouseData  = mouse_data_q;
  assign mouseState = state;
  assign init_done  = (state == S_STREAM);
  assign init_error = (state == S_ERROR);

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// tb/tb_mouse_init_ctrl.sv - self-checking bench for mouse_init_ctrl
module tb_mouse_init_ctrl;

  localparam int T  = 100;
  localparam int MR = 3;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       start    = 1'b0;
  logic       tx_busy  = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       mouseReady;
  logic [7:0] mouseData;
  logic [3:0] mouseState;
  logic       init_done;
  logic       init_error;

  mouse_init_ctrl #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .mouseReady (mouseReady),
    .mouseData  (mouseData),
    .mouseState (mouseState),
    .init_done  (init_done),
    .init_error (init_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] txlog[$];
  int         txcyc[$];
  logic [7:0] rxlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The init sequence is a list of commands, each with a list of replies.
  localparam int P_IDLE = 0, P_INIT = 1, P_STREAM = 2, P_ERR = 3;
  int         m_phase   = P_IDLE;
  int         m_cmd     = 0;
  int         m_pos     = 0;
  int         m_retries = 0;
  int         m_wait    = 0;
  bit         m_sending = 1'b0;
  bit         m_rdy     = 1'b0;
  logic [7:0] m_txd     = 8'h00;
  logic [7:0] m_dat     = 8'h00;

  function automatic int n_cmds();
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
    return 4;
`else
    return 2;
`endif
  endfunction

  function automatic logic [7:0] cmd_byte(input int c);
    if (c == 0) return 8'hFF;
    if (c == n_cmds() - 1) return 8'hF4;
    return (c == 1) ? 8'hF3 : 8'h64;
  endfunction

  function automatic int n_replies(input int c);
    return (c == 0) ? 3 : 1;
  endfunction

  function automatic logic [7:0] reply(input int c, input int p);
    if (c != 0) return 8'hFA;
    if (p == 0) return 8'hFA;
    if (p == 1) return 8'hAA;
    return 8'h00;
  endfunction

  function automatic logic [3:0] code_of(input int ph, input int c, input bit s, input int p);
    if (ph == P_IDLE)   return 4'd0;
    if (ph == P_STREAM) return 4'd7;
    if (ph == P_ERR)    return 4'd8;
    if (c == 0) return s ? 4'd1 : 4'(2 + p);
    if (c == n_cmds() - 1) return s ? 4'd5 : 4'd6;
    return s ? 4'(7 + 2 * c) : 4'(8 + 2 * c);
  endfunction

  task m_begin();
    m_phase   = P_INIT;
    m_cmd     = 0;
    m_sending = 1'b1;
    m_retries = 0;
    m_txd     = cmd_byte(0);
  endtask

  task m_failure(input bit resend);
    if (m_retries < MR) begin
      m_retries++;
      if (!resend) m_cmd = 0;
      m_sending = 1'b1;
      m_txd     = cmd_byte(m_cmd);
    end else begin
      m_phase = P_ERR;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_phase = P_IDLE; m_cmd = 0; m_pos = 0; m_retries = 0; m_wait = 0;
      m_sending = 1'b0; m_rdy = 1'b0; m_txd = 8'h00; m_dat = 8'h00;
    end else begin
      cyc++;
      m_rdy = 1'b0;
      case (m_phase)
        P_IDLE, P_ERR: if (start) m_begin();
        P_STREAM: begin
          if (start) m_begin();
          else if (rx_ready) begin m_rdy = 1'b1; m_dat = rx_data; end
        end
        default: begin
          if (m_sending) begin
            if (!tx_busy) begin m_sending = 1'b0; m_pos = 0; m_wait = 0; end
          end else if (rx_ready && rx_data == reply(m_cmd, m_pos)) begin
            if (m_pos + 1 < n_replies(m_cmd)) begin m_pos++; m_wait = 0; end
            else if (m_cmd == n_cmds() - 1) m_phase = P_STREAM;
            else begin m_cmd++; m_sending = 1'b1; m_txd = cmd_byte(m_cmd); end
          end else if (rx_ready) begin
            m_failure(rx_data == 8'hFE);
          end else if (m_wait >= T) begin
            m_failure(1'b0);
          end else begin
            m_wait++;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("mouseState", 32'(mouseState), 32'(code_of(m_phase, m_cmd, m_sending, m_pos)));
    chk("tx_start", 32'(tx_start), 32'(m_phase == P_INIT && m_sending && !tx_busy));
    chk("tx_data", 32'(tx_data), 32'(m_txd));
    chk("mouseReady", 32'(mouseReady), 32'(m_rdy));
    chk("mouseData", 32'(mouseData), 32'(m_dat));
    chk("init_done", 32'(init_done), 32'(m_phase == P_STREAM));
    chk("init_error", 32'(init_error), 32'(m_phase == P_ERR));
    if (tx_start === 1'b1) begin txlog.push_back(tx_data); txcyc.push_back(cyc); end
    if (mouseReady === 1'b1) rxlog.push_back(mouseData);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b; rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, input string name);
    int n = 0;
    while (mouseState !== code && n < budget) begin tick(1); n++; end
    chk(name, 32'(mouseState), 32'(code));
  endtask

  task automatic cmp_log(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic reset_replies();
    wait_state(4'd2, 20, "reach_wait_ack_rst");
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
  endtask

  task automatic enable_replies();
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
    wait_state(4'd10, 20, "reach_wait_ack_sr");
    send_rx(8'hFA);
    wait_state(4'd12, 20, "reach_wait_ack_rate");
    send_rx(8'hFA);
`endif
    wait_state(4'd6, 20, "reach_wait_ack_en");
    send_rx(8'hFA);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] exp_nom[$];
    logic [7:0] exp_resend[$];
    logic [7:0] exp_stream[$];
    int n;
    int gap;
    int ff_count;

`ifdef MOUSE_INIT_SAMPLE_RATE_EN
    exp_nom    = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
    exp_resend = '{8'hFF, 8'hF3, 8'h64, 8'hF4, 8'hF4};
`else
    exp_nom    = '{8'hFF, 8'hF4};
    exp_resend = '{8'hFF, 8'hF4, 8'hF4};
`endif
    exp_stream = '{8'h08, 8'h05, 8'hFB};

    // Reset state
    tick(3);
    chk("rst_state", 32'(mouseState), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_ready", 32'(mouseReady), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_error", 32'(init_error), 32'd0);
    rst = 1'b1;
    tick(3);
    chk("idle_hold", 32'(mouseState), 32'd0);

    // Nominal init
    txlog.delete();
    pulse_start();
    chk("start_to_send_rst", 32'(mouseState), 32'd1);
    reset_replies();
    enable_replies();
    chk("nominal_done", 32'(init_done), 32'd1);
    chk("nominal_state", 32'(mouseState), 32'd7);
    cmp_log("nominal_tx", txlog, exp_nom);

    // Stream pass-through
    rxlog.delete();
    send_rx(8'h08);
    chk("stream_latency", 32'(mouseReady), 32'd1);
    chk("stream_byte0", 32'(mouseData), 32'h08);
    tick(1);
    chk("stream_one_cycle", 32'(mouseReady), 32'd0);
    tick(1);
    send_rx(8'h05);
    tick(1);
    send_rx(8'hFB);
    tick(2);
    cmp_log("stream_rx", rxlog, exp_stream);

    // Start in STREAM with a simultaneous byte, busy transmitter, then FE on enable
    txlog.delete();
    rxlog.delete();
    tx_busy = 1'b1;
    start = 1'b1; rx_ready = 1'b1; rx_data = 8'h3C;
    tick(1);
    start = 1'b0; rx_ready = 1'b0;
    chk("restart_state", 32'(mouseState), 32'd1);
    chk("restart_ready_low", 32'(mouseReady), 32'd0);
    tick(3);
    chk("send_hold_busy", 32'(mouseState), 32'd1);
    tx_busy = 1'b0;
    reset_replies();
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
    wait_state(4'd10, 20, "reach_wait_ack_sr");
    send_rx(8'hFA);
    wait_state(4'd12, 20, "reach_wait_ack_rate");
    send_rx(8'hFA);
`endif
    wait_state(4'd6, 20, "reach_wait_ack_en");
    send_rx(8'hFE);
    chk("resend_to_send_en", 32'(mouseState), 32'd5);
    wait_state(4'd6, 20, "resend_wait_ack_en");
    send_rx(8'hFA);
    chk("resend_stream", 32'(mouseState), 32'd7);
    cmp_log("resend_tx", txlog, exp_resend);
    chk("dropped_byte", 32'(rxlog.size()), 32'd0);

    // Unexpected ID byte restarts from the reset command
    pulse_start();
    wait_state(4'd2, 20, "reach_wait_ack_rst");
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h55);
    chk("unexpected_retry", 32'(mouseState), 32'd1);
    reset_replies();
    enable_replies();
    chk("unexpected_recover", 32'(mouseState), 32'd7);

    // Timeout: silent device
    txlog.delete();
    txcyc.delete();
    pulse_start();
    n = 0;
    while (init_error !== 1'b1 && n < 2000) begin tick(1); n++; end
    chk("timeout_error", 32'(init_error), 32'd1);
    chk("timeout_state", 32'(mouseState), 32'd8);
    chk("timeout_sends", 32'(txlog.size()), 32'd4);
    ff_count = 0;
    foreach (txlog[i]) if (txlog[i] == 8'hFF) ff_count++;
    chk("timeout_ff_count", 32'(ff_count), 32'd4);
    gap = (txcyc.size() >= 2) ? (txcyc[1] - txcyc[0]) : 0;
    chk("timeout_resend_gap", 32'(gap), 32'd102);
    tick(5);
    chk("error_hold", 32'(mouseState), 32'd8);

    // Restart from ERROR, then asynchronous reset during WAIT_BAT
    pulse_start();
    chk("error_restart", 32'(mouseState), 32'd1);
    wait_state(4'd2, 20, "reach_wait_ack_rst");
    send_rx(8'hFA);
    chk("in_wait_bat", 32'(mouseState), 32'd3);
    tick(2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_state", 32'(mouseState), 32'd0);
    chk("async_tx_start", 32'(tx_start), 32'd0);
    chk("async_tx_data", 32'(tx_data), 32'h00);
    chk("async_ready", 32'(mouseReady), 32'd0);
    chk("async_data", 32'(mouseData), 32'h00);
    chk("async_done", 32'(init_done), 32'd0);
    chk("async_error", 32'(init_error), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("idle_after_reset", 32'(mouseState), 32'd0);

    // Full init again after reset
    txlog.delete();
    pulse_start();
    reset_replies();
    enable_replies();
    chk("final_stream", 32'(mouseState), 32'd7);
    cmp_log("final_tx", txlog, exp_nom);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
